// File: rtl/spi_mem_loader.sv
// SPI-to-RAM loader: oversamples SPI in the clk domain, takes one address word
// then a burst of data words, and emits one-hot bank write strobes with auto-increment.
module spi_mem_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LOCAL_W   = 13,
    parameter int unsigned BANK_BITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_sck,
    input  logic                        spi_mosi,
    input  logic                        spi_ss_n,
    output logic [(1<<BANK_BITS)-1:0]   wr_en,
    output logic [LOCAL_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [DATA_W-1:0]           last_data,
    output logic                        busy,
    output logic                        frame_err
);
    localparam int unsigned NUM_BANKS = 1 << BANK_BITS;
    localparam int unsigned SHIFT_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W     = $clog2(SHIFT_W + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic mosi_s1_q, mosi_s2_q;
    logic ss_s1_q, ss_s2_q, ss_h_q;
    logic [1:0] settle_q, settle_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d, shift_in;
    logic [BANK_BITS-1:0]   bank_q, bank_d;
    logic [NUM_BANKS-1:0]   wr_en_q, wr_en_d;
    logic [LOCAL_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic [DATA_W-1:0]      last_data_q, last_data_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   edges_ok, sck_rise, ss_fall, ss_rise;

    // Edges are ignored until the synchroniser and history stages hold real samples,
    // so a select held low through reset is not mistaken for a new frame start.
    always_comb begin
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        edges_ok = (settle_q == 2'd3);
        sck_rise = edges_ok & sck_s2_q & ~sck_h_q;
        ss_fall  = edges_ok & ~ss_s2_q & ss_h_q;
        ss_rise  = edges_ok & ss_s2_q & ~ss_h_q;
        shift_in = {shift_q[SHIFT_W-2:0], mosi_s2_q};
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        bank_d      = bank_q;
        wr_en_d     = '0;
        wr_addr_d   = (wr_en_q != '0) ? wr_addr_q + LOCAL_W'(1) : wr_addr_q;
        wr_data_d   = wr_data_q;
        last_data_d = last_data_q;
        frame_err_d = frame_err_q;

        if (ss_fall) begin
            state_d     = ADDR;
            bit_cnt_d   = '0;
            frame_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (sck_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            wr_addr_d = shift_in[LOCAL_W-1:0];
                            bank_d    = shift_in[LOCAL_W +: BANK_BITS];
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (ss_rise) begin
                        state_d     = IDLE;
                        frame_err_d = (bit_cnt_d != '0);
                    end
                end
                DATA: begin
                    // A final bit coincident with ss_rise is still written.
                    if (sck_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            wr_data_d       = shift_in[DATA_W-1:0];
                            last_data_d     = shift_in[DATA_W-1:0];
                            wr_en_d[bank_q] = 1'b1;
                            bit_cnt_d       = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (ss_rise) begin
                        state_d     = IDLE;
                        frame_err_d = (bit_cnt_d != '0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_h_q     <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            ss_h_q      <= 1'b1;
            settle_q    <= 2'd0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bank_q      <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            last_data_q <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_s1_q    <= spi_sck;
            sck_s2_q    <= sck_s1_q;
            sck_h_q     <= sck_s2_q;
            mosi_s1_q   <= spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
            ss_s1_q     <= spi_ss_n;
            ss_s2_q     <= ss_s1_q;
            ss_h_q      <= ss_s2_q;
            settle_q    <= settle_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bank_q      <= bank_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            last_data_q <= last_data_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign last_data = last_data_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: directed frames plus random frames against a bit-stream model,
// on a default-parameter instance and a 4-bank / 12-bit-local instance sharing the SPI lines.
module tb_spi_mem_loader;
    logic clk = 1'b0;
    logic rst, sck, mosi, ss_n;
    always #5 clk = ~clk;

    logic [1:0]  a_wr_en;  logic [12:0] a_wr_addr; logic [7:0] a_wr_data, a_last_data; logic a_busy, a_frame_err;
    logic [3:0]  b_wr_en;  logic [11:0] b_wr_addr; logic [7:0] b_wr_data, b_last_data; logic b_busy, b_frame_err;

    spi_mem_loader dut_a (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_ss_n(ss_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .last_data(a_last_data), .busy(a_busy), .frame_err(a_frame_err)
    );

    spi_mem_loader #(.ADDR_W(16), .DATA_W(8), .LOCAL_W(12), .BANK_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_ss_n(ss_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .last_data(b_last_data), .busy(b_busy), .frame_err(b_frame_err)
    );

    typedef struct {
        logic [3:0]  en;
        logic [12:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol_a = 0;
    int viol_b = 0;
    logic [1:0] prev_a = '0;
    logic [3:0] prev_b = '0;
    wr_t qa[$], qb[$], em[$];
    bit  frame_bits[$];
    int  rise_cyc[$];
    bit  exp_err;
    int  exp_nw;
    logic [7:0] exp_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe and counts multi-hot or back-to-back strobes.
    always @(negedge clk) begin
        if (a_wr_en != '0) qa.push_back('{4'(a_wr_en), 13'(a_wr_addr), a_wr_data, cyc});
        if (b_wr_en != '0) qb.push_back('{b_wr_en, 13'(b_wr_addr), b_wr_data, cyc});
        if ($countones(a_wr_en) > 1 || (prev_a & a_wr_en) != '0) viol_a <= viol_a + 1;
        if ($countones(b_wr_en) > 1 || (prev_b & b_wr_en) != '0) viol_b <= viol_b + 1;
        prev_a <= a_wr_en;
        prev_b <= b_wr_en;
    end

    task automatic push_word(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame_bits.push_back(v[i]);
    endtask

    task automatic send_frame(input bit coinc);
        rise_cyc.delete(); qa.delete(); qb.delete();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < frame_bits.size(); i++) begin
            mosi = frame_bits[i];
            repeat (8) @(negedge clk);
            sck = 1'b1;
            rise_cyc.push_back(cyc);
            if (coinc && i == frame_bits.size() - 1) ss_n = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        if (!coinc) begin
            repeat (8) @(negedge clk);
            ss_n = 1'b1;
        end
        repeat (12) @(negedge clk);
    endtask

    // Reference: decode the bit stream as address word, whole data words, remainder.
    function automatic void model_frame(input int lw, input int bb);
        int n, loc, bank, nw;
        logic [15:0] addr;
        logic [7:0]  data;
        em.delete();
        n = frame_bits.size();
        exp_err = 1'b0;
        exp_nw = 0;
        if (n < 16) begin
            exp_err = (n != 0);
            return;
        end
        addr = '0;
        for (int i = 0; i < 16; i++) addr = {addr[14:0], frame_bits[i]};
        loc  = int'(addr) % (1 << lw);
        bank = (int'(addr) >> lw) % (1 << bb);
        nw = (n - 16) / 8;
        exp_err = ((n - 16) % 8) != 0;
        exp_nw = nw;
        for (int w = 0; w < nw; w++) begin
            data = '0;
            for (int b = 0; b < 8; b++) data = {data[6:0], frame_bits[16 + 8*w + b]};
            em.push_back('{4'(1 << bank), 13'((loc + w) % (1 << lw)), data, rise_cyc[16 + 8*w + 7]});
            exp_last = data;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_wr_en !== 2'b00)       begin errors++; $display("FAIL reset_wr_en: got %b want 00", a_wr_en); end
        checks++; if (a_wr_addr !== 13'h0)     begin errors++; $display("FAIL reset_wr_addr: got %h want 0", a_wr_addr); end
        checks++; if (a_wr_data !== 8'h0)      begin errors++; $display("FAIL reset_wr_data: got %h want 0", a_wr_data); end
        checks++; if (a_last_data !== 8'h0)    begin errors++; $display("FAIL reset_last_data: got %h want 0", a_last_data); end
        checks++; if (a_busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++; if (a_frame_err !== 1'b0)    begin errors++; $display("FAIL reset_frame_err: got %b want 0", a_frame_err); end
    endtask

    task automatic test_single();
        int lat;
        frame_bits.delete();
        push_word(16'h2005, 16); push_word(16'h00A5, 8);
        send_frame(1'b0);
        checks++; if (qa.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", qa.size()); end
        else begin
            lat = qa[0].cyc - rise_cyc[23];
            checks++; if (qa[0].en !== 4'b0010)   begin errors++; $display("FAIL single_en: got %b want 0010", qa[0].en); end
            checks++; if (qa[0].addr !== 13'h5)   begin errors++; $display("FAIL single_addr: got %h want 0005", qa[0].addr); end
            checks++; if (qa[0].data !== 8'hA5)   begin errors++; $display("FAIL single_data: got %h want a5", qa[0].data); end
            checks++; if (lat < 3 || lat > 4)     begin errors++; $display("FAIL single_latency: got %0d want 3..4", lat); end
        end
        checks++; if (a_last_data !== 8'hA5)   begin errors++; $display("FAIL single_last_data: got %h want a5", a_last_data); end
        checks++; if (a_frame_err !== 1'b0)    begin errors++; $display("FAIL single_frame_err: got %b want 0", a_frame_err); end
    endtask

    task automatic test_burst();
        logic [12:0] ea[3];
        logic [7:0]  ed[3];
        ea = '{13'h1FFE, 13'h1FFF, 13'h0000};
        ed = '{8'h11, 8'h22, 8'h33};
        frame_bits.delete();
        push_word(16'h1FFE, 16); push_word(16'h11, 8); push_word(16'h22, 8); push_word(16'h33, 8);
        send_frame(1'b0);
        checks++; if (qa.size() !== 3) begin errors++; $display("FAIL burst_count: got %0d want 3", qa.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (qa[i].en !== 4'b0001 || qa[i].addr !== ea[i] || qa[i].data !== ed[i]) begin
                errors++;
                $display("FAIL burst_w%0d: got en=%b addr=%h data=%h want en=0001 addr=%h data=%h",
                         i, qa[i].en, qa[i].addr, qa[i].data, ea[i], ed[i]);
            end
        end
        checks++; if (a_frame_err !== 1'b0)  begin errors++; $display("FAIL burst_frame_err: got %b want 0", a_frame_err); end
        checks++; if (a_last_data !== 8'h33) begin errors++; $display("FAIL burst_last_data: got %h want 33", a_last_data); end
    endtask

    task automatic test_partial();
        frame_bits.delete();
        push_word(16'h0010, 16); push_word(16'h44, 8); push_word(16'h16, 5);
        send_frame(1'b0);
        checks++; if (qa.size() !== 1) begin errors++; $display("FAIL partial_count: got %0d want 1", qa.size()); end
        else begin
            checks++;
            if (qa[0].addr !== 13'h10 || qa[0].data !== 8'h44) begin
                errors++; $display("FAIL partial_write: got addr=%h data=%h want 0010/44", qa[0].addr, qa[0].data);
            end
        end
        checks++; if (a_frame_err !== 1'b1) begin errors++; $display("FAIL partial_frame_err: got %b want 1", a_frame_err); end
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL partial_err_clear: got %b want 0", a_frame_err); end
        checks++; if (a_busy !== 1'b1)      begin errors++; $display("FAIL partial_busy: got %b want 1", a_busy); end
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL empty_frame_err: got %b want 0", a_frame_err); end
    endtask

    task automatic test_reset_mid();
        frame_bits.delete();
        push_word(16'h0234, 16); push_word(16'h66, 8);
        qa.delete(); qb.delete();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            if (i == 10) begin
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", a_busy); end
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            mosi = frame_bits[i];
            repeat (8) @(negedge clk);
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        repeat (20) @(negedge clk);
        checks++; if (qa.size() + qb.size() !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes want 0", qa.size() + qb.size()); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b%b want 00", a_busy, b_busy); end
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        frame_bits.delete();
        push_word(16'h0123, 16); push_word(16'h77, 8);
        send_frame(1'b0);
        checks++;
        if (qa.size() !== 1) begin errors++; $display("FAIL rstmid_recover: got %0d writes want 1", qa.size()); end
        else if (qa[0].en !== 4'b0001 || qa[0].addr !== 13'h123 || qa[0].data !== 8'h77) begin
            errors++; $display("FAIL rstmid_recover: got en=%b addr=%h data=%h want 0001/0123/77", qa[0].en, qa[0].addr, qa[0].data);
        end
    endtask

    task automatic test_banks();
        frame_bits.delete();
        push_word(16'h3ABC, 16); push_word(16'h5A, 8);
        send_frame(1'b0);
        checks++;
        if (qb.size() !== 1) begin errors++; $display("FAIL bank4_count: got %0d want 1", qb.size()); end
        else if (qb[0].en !== 4'b1000 || qb[0].addr !== 13'hABC || qb[0].data !== 8'h5A) begin
            errors++; $display("FAIL bank4_write: got en=%b addr=%h data=%h want 1000/abc/5a", qb[0].en, qb[0].addr, qb[0].data);
        end
        checks++;
        if (qa.size() !== 1) begin errors++; $display("FAIL bank2_count: got %0d want 1", qa.size()); end
        else if (qa[0].en !== 4'b0010 || qa[0].addr !== 13'h1ABC) begin
            errors++; $display("FAIL bank2_write: got en=%b addr=%h want 0010/1abc", qa[0].en, qa[0].addr);
        end
    endtask

    task automatic test_coincident();
        frame_bits.delete();
        push_word(16'h0042, 16); push_word(16'h99, 8);
        send_frame(1'b1);
        checks++;
        if (qa.size() !== 1) begin errors++; $display("FAIL coinc_count: got %0d want 1", qa.size()); end
        else if (qa[0].addr !== 13'h42 || qa[0].data !== 8'h99) begin
            errors++; $display("FAIL coinc_write: got addr=%h data=%h want 0042/99", qa[0].addr, qa[0].data);
        end
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL coinc_frame_err: got %b want 0", a_frame_err); end
        checks++; if (a_busy !== 1'b0)      begin errors++; $display("FAIL coinc_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_random();
        logic [7:0] mdl_last[2];
        wr_t obs[$];
        int nbits, lat;
        mdl_last = '{8'h99, 8'h99};
        for (int f = 0; f < 24; f++) begin
            frame_bits.delete();
            if ($urandom_range(0, 5) == 0) nbits = $urandom_range(1, 15);
            else nbits = 16 + 8 * $urandom_range(0, 3) + (($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
            for (int i = 0; i < nbits; i++) frame_bits.push_back(bit'($urandom_range(0, 1)));
            send_frame(1'b0);
            for (int d = 0; d < 2; d++) begin
                model_frame(d == 0 ? 13 : 12, d == 0 ? 1 : 2);
                if (exp_nw > 0) mdl_last[d] = exp_last;
                if (d == 0) obs = qa; else obs = qb;
                checks++;
                if (obs.size() !== em.size()) begin
                    errors++; $display("FAIL rand_f%0d_d%0d_count: got %0d want %0d", f, d, obs.size(), em.size());
                end else for (int i = 0; i < em.size(); i++) begin
                    lat = obs[i].cyc - em[i].cyc;
                    checks++;
                    if (obs[i].en !== em[i].en || obs[i].addr !== em[i].addr || obs[i].data !== em[i].data || lat < 3 || lat > 4) begin
                        errors++;
                        $display("FAIL rand_f%0d_d%0d_w%0d: got en=%b addr=%h data=%h lat=%0d want en=%b addr=%h data=%h lat=3..4",
                                 f, d, i, obs[i].en, obs[i].addr, obs[i].data, lat, em[i].en, em[i].addr, em[i].data);
                    end
                end
                checks++;
                if ((d == 0 ? a_frame_err : b_frame_err) !== exp_err) begin
                    errors++; $display("FAIL rand_f%0d_d%0d_frame_err: got %b want %b", f, d, d == 0 ? a_frame_err : b_frame_err, exp_err);
                end
                checks++;
                if ((d == 0 ? a_last_data : b_last_data) !== mdl_last[d]) begin
                    errors++; $display("FAIL rand_f%0d_d%0d_last_data: got %h want %h", f, d, d == 0 ? a_last_data : b_last_data, mdl_last[d]);
                end
            end
        end
        checks++; if (viol_a !== 0) begin errors++; $display("FAIL onehot_a: got %0d violations want 0", viol_a); end
        checks++; if (viol_b !== 0) begin errors++; $display("FAIL onehot_b: got %0d violations want 0", viol_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_partial();
        test_reset_mid();
        test_banks();
        test_coincident();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
